uart_rx_fifo: RTL and testbench

//  Parametrised UART receiver with a receive FIFO, error flags and optional parity.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_sync_fifo.sv | 60 ++++++
 rtl/uart_rx_fifo.sv | 184 ++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART receive path.
//   rx_state_t   receiver FSM states
//   PARITY_EVEN  parity sense constant (XOR of data bits gives the parity bit)
//   PARITY_ODD   parity sense constant (inverted XOR gives the parity bit)
//   baud_div()   clock-to-baud divisor helper
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BREAK
   } rx_state_t;

   localparam logic PARITY_EVEN = 1'b0;
   localparam logic PARITY_ODD  = 1'b1;

   // Truncated divisor minus one: 100 MHz / 9600 baud gives 10415.
   function automatic int baud_div(input int clk_hz, input int baud);
      return clk_hz / baud - 1;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock show-ahead FIFO for received words.
//   Clk, Rst_n  clock and synchronous active-low reset (pointers and count only)
//   wr_en       write wr_data; dropped when full unless rd_en pops in the same cycle
//   wr_data     word to store
//   rd_en       pop the head; ignored when empty
//   rd_data     head word, 0 while empty
//   empty/full  occupancy flags
//   count       words held, 0..DEPTH
//   overflow    pulses when a write is dropped
module uart_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                       Clk,
   input  logic                       Rst_n,
   input  logic                       wr_en,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_wr;
   logic             do_rd;

   assign empty    = (count == '0);
   assign full     = (count == CW'(DEPTH));
   assign do_rd    = rd_en & ~empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
   assign do_wr    = wr_en & (~full | do_rd);
   assign overflow = wr_en & full & ~rd_en;
   assign rd_data  = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge Clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(do_wr) - CW'(do_rd);
      end
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver with optional parity, 1 or 2 stop bits,
// a show-ahead receive FIFO and sticky error flags.
//   Clk, Rst_n  clock and synchronous active-low reset
//   RX          asynchronous serial input, idles high
//   Rd_en       pop the FIFO head (ignored when Empty)
//   Clr_err     clear FE, PE and OE (a simultaneous new error wins)
//   data_out    FIFO head, valid while !Empty
//   Empty/Full  FIFO occupancy flags
//   Count       words in the FIFO
//   FE/PE/OE    sticky framing, parity and overrun errors
module uart_rx_fifo #(
   parameter int UBRR       = 10415,
   parameter int DATA_BITS  = 8,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1,
   parameter int DEPTH      = 8
) (
   input  logic                       Clk,
   input  logic                       Rst_n,
   input  logic                       RX,
   input  logic                       Rd_en,
   input  logic                       Clr_err,
   output logic [DATA_BITS-1:0]       data_out,
   output logic                       Empty,
   output logic                       Full,
   output logic [$clog2(DEPTH+1)-1:0] Count,
   output logic                       FE,
   output logic                       PE,
   output logic                       OE
);

   import uart_pkg::*;

   localparam int            TW        = $clog2(UBRR);
   localparam logic [TW-1:0] SAMPLE_PT = TW'(UBRR / 2);
   localparam logic [TW-1:0] LAST_TICK = TW'(UBRR - 1);
   localparam logic          PAR_SENSE = (PARITY_ODD != 0) ? uart_pkg::PARITY_ODD
                                                           : uart_pkg::PARITY_EVEN;

   logic                 rx_meta_p0;
   logic                 rx_s;
   rx_state_t            state, state_nxt;
   logic [TW-1:0]        timer, timer_nxt;
   logic [3:0]           bit_cnt, bit_cnt_nxt;
   logic [DATA_BITS-1:0] shift, shift_nxt;
   logic                 pe_pend, pe_pend_nxt;
   logic                 wr_en_p1, wr_en_nxt;
   logic                 fe_set, pe_set;
   logic                 fifo_ovf;
   logic                 sample;

   // Stage: two-flop synchroniser, preset to the idle level
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         rx_meta_p0 <= 1'b1;
         rx_s       <= 1'b1;
      end else begin
         rx_meta_p0 <= RX;
         rx_s       <= rx_meta_p0;
      end
   end

   // The timer restarts on the start edge and then free-runs modulo UBRR,
   // so every later match on SAMPLE_PT lands one bit period further on, mid-bit.
   assign sample = (timer == SAMPLE_PT);

   always_comb begin
      state_nxt   = state;
      timer_nxt   = (timer == LAST_TICK) ? '0 : timer + 1'b1;
      bit_cnt_nxt = bit_cnt;
      shift_nxt   = shift;
      pe_pend_nxt = pe_pend;
      wr_en_nxt   = 1'b0;
      fe_set      = 1'b0;
      pe_set      = 1'b0;
      unique case (state)
         IDLE: begin
            timer_nxt = '0;
            if (!rx_s) state_nxt = START;
         end
         START: begin
            if (sample) begin
               if (rx_s) begin
                  state_nxt = IDLE;
               end else begin
                  state_nxt   = DATA;
                  bit_cnt_nxt = '0;
                  pe_pend_nxt = 1'b0;
               end
            end
         end
         DATA: begin
            if (sample) begin
               shift_nxt = {rx_s, shift[DATA_BITS-1:1]};
               if (bit_cnt == 4'(DATA_BITS - 1)) begin
                  bit_cnt_nxt = '0;
                  state_nxt   = (PARITY_EN != 0) ? PARITY : STOP;
               end else begin
                  bit_cnt_nxt = bit_cnt + 1'b1;
               end
            end
         end
         PARITY: begin
            if (sample) begin
               if (rx_s != ((^shift) ^ PAR_SENSE)) pe_pend_nxt = 1'b1;
               state_nxt = STOP;
            end
         end
         STOP: begin
            if (sample) begin
               if (!rx_s) begin
                  fe_set    = 1'b1;
                  pe_set    = pe_pend;
                  state_nxt = BREAK;
               end else if (bit_cnt == 4'(STOP_BITS - 1)) begin
                  state_nxt = IDLE;
                  if (pe_pend) pe_set = 1'b1;
                  else         wr_en_nxt = 1'b1;
               end else begin
                  bit_cnt_nxt = bit_cnt + 1'b1;
               end
            end
         end
         BREAK: begin
            if (rx_s) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Stage: FSM, timer and write strobe registers
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state    <= IDLE;
         timer    <= '0;
         bit_cnt  <= '0;
         pe_pend  <= 1'b0;
         wr_en_p1 <= 1'b0;
      end else begin
         state    <= state_nxt;
         timer    <= timer_nxt;
         bit_cnt  <= bit_cnt_nxt;
         pe_pend  <= pe_pend_nxt;
         wr_en_p1 <= wr_en_nxt;
      end
   end

   // The shift register stays stable until the next frame's first data sample,
   // long after the write strobe has used it.
   always_ff @(posedge Clk) begin
      shift <= shift_nxt;
   end

   // Stage: sticky error flags; a new error outranks Clr_err
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         FE <= 1'b0;
         PE <= 1'b0;
         OE <= 1'b0;
      end else begin
         FE <= (FE & ~Clr_err) | fe_set;
         PE <= (PE & ~Clr_err) | pe_set;
         OE <= (OE & ~Clr_err) | fifo_ovf;
      end
   end

   uart_sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (DEPTH)
   ) u_fifo (
      .Clk      (Clk),
      .Rst_n    (Rst_n),
      .wr_en    (wr_en_p1),
      .wr_data  (shift),
      .rd_en    (Rd_en),
      .rd_data  (data_out),
      .empty    (Empty),
      .full     (Full),
      .count    (Count),
      .overflow (fifo_ovf)
   );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: two instances at one bit = 16 Clk.
//   dut0: 8N1, DEPTH=4
//   dut1: 8 data bits, even parity, 2 stop bits, DEPTH=8
module tb_uart_rx_fifo;

   localparam int BIT    = 16;
   localparam int ERR_AT = BIT/2 + 3 + BIT*9;   // dut0 stop-sample cycle
   localparam int WR_AT  = BIT/2 + 4 + BIT*9;   // dut0 FIFO write cycle

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst0_n, rx0, rd0, clr0;
   logic       rst1_n, rx1, rd1, clr1;
   logic [7:0] do0, do1;
   logic       em0, fu0, fe0, pe0, oe0;
   logic       em1, fu1, fe1, pe1, oe1;
   logic [2:0] cnt0;
   logic [3:0] cnt1;

   uart_rx_fifo #(.UBRR(BIT), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0),
                  .STOP_BITS(1), .DEPTH(4)) dut0 (
      .Clk(clk), .Rst_n(rst0_n), .RX(rx0), .Rd_en(rd0), .Clr_err(clr0),
      .data_out(do0), .Empty(em0), .Full(fu0), .Count(cnt0),
      .FE(fe0), .PE(pe0), .OE(oe0));

   uart_rx_fifo #(.UBRR(BIT), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0),
                  .STOP_BITS(2), .DEPTH(8)) dut1 (
      .Clk(clk), .Rst_n(rst1_n), .RX(rx1), .Rd_en(rd1), .Clr_err(clr1),
      .data_out(do1), .Empty(em1), .Full(fu1), .Count(cnt1),
      .FE(fe1), .PE(pe1), .OE(oe1));

   int         ntests = 0;
   int         nfail  = 0;
   logic [7:0] q0[$];
   logic [7:0] q1[$];
   logic       e_fe[2];
   logic       e_pe[2];
   logic       e_oe[2];

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int qsize(input int sel);
      return (sel == 0) ? q0.size() : q1.size();
   endfunction

   function automatic void qpop(input int sel);
      if (sel == 0) void'(q0.pop_front());
      else          void'(q1.pop_front());
   endfunction

   task automatic check(input int sel, input string tag);
      int         depth = (sel == 0) ? 4 : 8;
      int         n     = qsize(sel);
      logic [7:0] hd    = (n == 0) ? 8'h00 : ((sel == 0) ? q0[0] : q1[0]);
      chk({tag, " data_out"}, (sel == 0) ? 16'(do0) : 16'(do1), 16'(hd));
      chk({tag, " Empty"},    (sel == 0) ? 16'(em0) : 16'(em1), 16'(n == 0));
      chk({tag, " Full"},     (sel == 0) ? 16'(fu0) : 16'(fu1), 16'(n == depth));
      chk({tag, " Count"},    (sel == 0) ? 16'(cnt0) : 16'(cnt1), 16'(n));
      chk({tag, " FE"},       (sel == 0) ? 16'(fe0) : 16'(fe1), 16'(e_fe[sel]));
      chk({tag, " PE"},       (sel == 0) ? 16'(pe0) : 16'(pe1), 16'(e_pe[sel]));
      chk({tag, " OE"},       (sel == 0) ? 16'(oe0) : 16'(oe1), 16'(e_oe[sel]));
   endtask

   task automatic drive(input int sel, input logic v, input logic rd, input logic clr);
      if (sel == 0) begin rx0 = v; rd0 = rd; clr0 = clr; end
      else          begin rx1 = v; rd1 = rd; clr1 = clr; end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pop(input int sel);
      drive(sel, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      drive(sel, 1'b1, 1'b0, 1'b0);
      if (qsize(sel) > 0) qpop(sel);
   endtask

   task automatic clear(input int sel);
      drive(sel, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      drive(sel, 1'b1, 1'b0, 1'b0);
      e_fe[sel] = 1'b0; e_pe[sel] = 1'b0; e_oe[sel] = 1'b0;
   endtask

   // Reference: a frame with good stop bits and correct parity is queued,
   // or dropped with OE when full; bad parity sets PE, bad stop sets FE.
   task automatic model_frame(input int sel, input logic [7:0] d, input bit par_ok,
                              input bit stop_ok, input bit rd_same, input bit clr_same);
      int depth = (sel == 0) ? 4 : 8;
      if (clr_same) begin e_fe[sel] = 1'b0; e_pe[sel] = 1'b0; e_oe[sel] = 1'b0; end
      if (rd_same && qsize(sel) > 0) qpop(sel);
      if (!par_ok)  e_pe[sel] = 1'b1;
      if (!stop_ok) e_fe[sel] = 1'b1;
      if (par_ok && stop_ok) begin
         if (qsize(sel) < depth) begin
            if (sel == 0) q0.push_back(d); else q1.push_back(d);
         end else begin
            e_oe[sel] = 1'b1;
         end
      end
   endtask

   // par < 0: no parity bit; otherwise par[0] is the transmitted parity bit.
   task automatic frame(input int sel, input logic [7:0] d, input int par, input bit stop_ok,
                        input int rd_at, input int clr_at);
      int   nstop = (sel == 0) ? 1 : 2;
      int   nb    = 1 + 8 + ((par >= 0) ? 1 : 0) + nstop;
      bit   par_ok = (par < 0) || (par[0] == ^d);
      int   b;
      logic v;
      for (int c = 0; c < nb*BIT; c++) begin
         b = c / BIT;
         if (b == 0)                     v = 1'b0;
         else if (b <= 8)                v = d[b-1];
         else if (par >= 0 && b == 9)    v = par[0];
         else                            v = stop_ok;
         drive(sel, v, c == rd_at, c == clr_at);
         @(negedge clk);
      end
      drive(sel, v, 1'b0, 1'b0);
      model_frame(sel, d, par_ok, stop_ok, rd_at >= 0, clr_at >= 0);
   endtask

   logic [7:0] rd_byte;
   bit         bad;
   logic [7:0] first;

   initial begin
      rx0 = 1'b1; rd0 = 1'b0; clr0 = 1'b0; rst0_n = 1'b0;
      rx1 = 1'b1; rd1 = 1'b0; clr1 = 1'b0; rst1_n = 1'b0;
      for (int s = 0; s < 2; s++) begin e_fe[s] = 0; e_pe[s] = 0; e_oe[s] = 0; end
      repeat (3) @(negedge clk);
      rst0_n = 1'b1; rst1_n = 1'b1;
      idle(2);
      check(0, "reset0");
      check(1, "reset1");

      // Basic receive and pop
      frame(0, 8'hA5, -1, 1'b1, -1, -1);
      idle(2);
      check(0, "t1_rx_a5");
      pop(0);
      check(0, "t1_pop");
      pop(0);
      check(0, "t1_pop_empty");

      // False start, then a clean frame proves the FSM returned to IDLE
      drive(0, 1'b0, 1'b0, 1'b0);
      idle(4);
      drive(0, 1'b1, 1'b0, 1'b0);
      idle(3*BIT);
      check(0, "t2_false_start");
      frame(0, 8'h96, -1, 1'b1, -1, -1);
      check(0, "t2_after");
      pop(0);

      // Framing error, break, recovery and flag priority
      frame(0, 8'h3C, -1, 1'b0, -1, -1);
      check(0, "t3_fe");
      idle(40);
      drive(0, 1'b1, 1'b0, 1'b0);
      idle(BIT);
      frame(0, 8'h3C, -1, 1'b0, -1, ERR_AT);
      check(0, "t3_clr_vs_err");
      drive(0, 1'b1, 1'b0, 1'b0);
      idle(BIT);
      frame(0, 8'h11, -1, 1'b1, -1, -1);
      check(0, "t3_rx_11");
      clear(0);
      check(0, "t3_clr");
      pop(0);

      // Parity
      frame(1, 8'h07, 1, 1'b1, -1, -1);
      check(1, "t4_par_ok");
      frame(1, 8'h07, 0, 1'b1, -1, -1);
      check(1, "t4_par_bad");
      clear(1);
      pop(1);
      check(1, "t4_drain");

      // Overrun and simultaneous read/write while full
      for (int i = 0; i < 5; i++) begin
         rd_byte = 8'($urandom);
         if (i == 0) first = rd_byte;
         frame(0, rd_byte, -1, 1'b1, -1, -1);
      end
      check(0, "t5_full");
      chk("t5_head_first", 16'(do0), 16'(first));
      clear(0);
      frame(0, 8'hC3, -1, 1'b1, WR_AT, -1);
      check(0, "t5_rdwr_full");
      while (qsize(0) > 0) begin
         pop(0);
         check(0, "t5_drain");
      end

      // Reset mid-frame
      for (int c = 0; c < 3*BIT; c++) begin
         drive(0, (c < BIT) ? 1'b0 : 1'b1, 1'b0, 1'b0);
         @(negedge clk);
      end
      frame(0, 8'h77, -1, 1'b1, -1, -1);
      drive(0, 1'b0, 1'b0, 1'b0);
      idle(3*BIT);
      rst0_n = 1'b0;
      drive(0, 1'b1, 1'b0, 1'b0);
      idle(2);
      rst0_n = 1'b1;
      q0.delete();
      e_fe[0] = 0; e_pe[0] = 0; e_oe[0] = 0;
      idle(2*BIT);
      check(0, "t6_after_reset");
      frame(0, 8'h5A, -1, 1'b1, -1, -1);
      check(0, "t6_rx_5a");
      pop(0);

      // Randomised frames against the reference model
      for (int i = 0; i < 16; i++) begin
         bad = ($urandom_range(0, 5) == 0);
         frame(0, 8'($urandom), -1, !bad, -1, -1);
         if (bad) begin
            idle($urandom_range(0, 30));
            drive(0, 1'b1, 1'b0, 1'b0);
         end
         idle($urandom_range(2, 20));
         check(0, "rnd0");
         repeat ($urandom_range(0, 2)) pop(0);
         if ($urandom_range(0, 7) == 0) clear(0);
      end
      for (int i = 0; i < 16; i++) begin
         rd_byte = 8'($urandom);
         bad = ($urandom_range(0, 3) == 0);
         frame(1, rd_byte, int'((^rd_byte) ^ bad), 1'b1, -1, -1);
         idle($urandom_range(2, 20));
         check(1, "rnd1");
         repeat ($urandom_range(0, 2)) pop(1);
         if ($urandom_range(0, 5) == 0) clear(1);
      end

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
